mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_mem_pkg.sv | 56 +++++
 rtl/wait_timer.sv | 31 +++
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-access controller: state encoding, op codes,
// timeout width and the control-strobe bundle decoded from each state.
package cpu_mem_pkg;

    localparam int unsigned TO_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAR_LD  = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        WR_MDR  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef struct packed {
        logic mar_in;
        logic mdr_in;
        logic mdr_read;
        logic mem_read;
        logic mem_write;
        logic busy;
        logic done;
    } ctrl_t;

    // Moore decode of the datapath strobes for a given state
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != IDLE);
        case (s)
            MAR_LD:  c.mar_in = 1'b1;
            RD_WAIT: begin
                c.mem_read = 1'b1;
                c.mdr_read = 1'b1;
            end
            RD_CAP:  begin
                c.mdr_in   = 1'b1;
                c.mdr_read = 1'b1;
            end
            WR_MDR:  c.mdr_in    = 1'b1;
            WR_WAIT: c.mem_write = 1'b1;
            DONE:    c.done      = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts memory wait cycles (1 on the first wait cycle, saturating) and flags
// when the count reaches a nonzero limit.
module wait_timer
    import cpu_mem_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic            en,
    input  logic [TO_W-1:0] lim,
    output logic            expired
);

    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= TO_W'(1);
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // A zero limit disables the timeout entirely
    assign expired = (lim != '0) && (cnt == lim);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MAR/MDR loads and memory strobes for one read or write at a time,
// with an optional wait-cycle timeout reported through a sticky err flag.
module mem_access_ctrl
    import cpu_mem_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic            rd_req,
    input  logic            wr_req,
    input  logic            mem_ack,
    input  logic [TO_W-1:0] timeout_lim,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_read,
    output logic            mem_read,
    output logic            mem_write,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t          state, state_nxt;
    op_t             op, op_nxt;
    logic [TO_W-1:0] lim_q, lim_nxt;
    logic            err_nxt;
    ctrl_t           ctrl_q, ctrl_nxt;
    logic            tmr_start, tmr_en, expired;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            op     <= OP_READ;
            lim_q  <= '0;
            err    <= 1'b0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            op     <= op_nxt;
            lim_q  <= lim_nxt;
            err    <= err_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        lim_nxt   = lim_q;
        err_nxt   = err;
        tmr_start = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                // Read has priority; a simultaneous write is dropped
                if (rd_req || wr_req) begin
                    state_nxt = MAR_LD;
                    op_nxt    = rd_req ? OP_READ : OP_WRITE;
                    lim_nxt   = timeout_lim;
                    err_nxt   = 1'b0;
                end
            end
            MAR_LD: begin
                if (op == OP_READ) begin
                    state_nxt = RD_WAIT;
                    tmr_start = 1'b1;
                end else begin
                    state_nxt = WR_MDR;
                end
            end
            RD_WAIT: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    state_nxt = RD_CAP;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            RD_CAP: state_nxt = DONE;
            WR_MDR: begin
                state_nxt = WR_WAIT;
                tmr_start = 1'b1;
            end
            WR_WAIT: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (expired) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == ERR) begin
            err_nxt = 1'b1;
        end
        // Strobes are registered from the next state so they track the state register
        ctrl_nxt = decode_ctrl(state_nxt);
    end

    wait_timer u_wait_timer (
        .clock   (clock),
        .clear   (clear),
        .start   (tmr_start),
        .en      (tmr_en),
        .lim     (lim_q),
        .expired (expired)
    );

    assign {mar_in, mdr_in, mdr_read, mem_read, mem_write, busy, done} = ctrl_q;

endmodule
